// File: rtl/spi_bus_bridge.sv
// spi_bus_bridge: turns one-cycle SPI read/write strobes into a req/ack register-bus
// transaction with bus timeout, fixed timeout read pattern and sticky error flags. Rev 1.0
`default_nettype none

module spi_bus_bridge #(
  parameter int              ASZ      = 7,
  parameter int              DSZ      = 32,
  parameter int              TMO      = 16,
  parameter logic [DSZ-1:0]  TMO_DATA = 32'hDEADBEEF
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [ASZ-1:0] spi_addr,
  input  logic [DSZ-1:0] spi_wdata,
  input  logic           spi_wr_en,
  input  logic           spi_rd_en,
  output logic [DSZ-1:0] spi_rdata,
  output logic [ASZ-1:0] bus_addr,
  output logic [DSZ-1:0] bus_wdata,
  output logic           bus_we,
  output logic           bus_req,
  input  logic           bus_ack,
  input  logic [DSZ-1:0] bus_rdata,
  output logic           busy,
  output logic           err_timeout,
  output logic           err_overrun,
  input  logic           err_clr
);

  localparam int            TW       = (TMO > 2) ? $clog2(TMO) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t         state_q;
  logic [TW-1:0]  timer_q;
  logic [DSZ-1:0] rdata_q;
  logic [ASZ-1:0] addr_q;
  logic [DSZ-1:0] wdata_q;
  logic           we_q;
  logic           req_q;
  logic           tmo_flag_q;
  logic           ovr_flag_q;

  logic strobe_d;
  logic ovr_set_d;
  logic tmo_set_d;

  // In WAIT any strobe is dropped; in IDLE only a double strobe is an overrun.
  assign strobe_d  = spi_wr_en | spi_rd_en;
  assign ovr_set_d = (state_q == IDLE) ? (spi_wr_en & spi_rd_en) : strobe_d;
  assign tmo_set_d = (state_q == WAIT) && !bus_ack && (timer_q == TMO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      rdata_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      req_q      <= 1'b0;
      tmo_flag_q <= 1'b0;
      ovr_flag_q <= 1'b0;
    end else begin
      if (ovr_set_d) begin
        ovr_flag_q <= 1'b1;
      end else if (err_clr) begin
        ovr_flag_q <= 1'b0;
      end

      if (tmo_set_d) begin
        tmo_flag_q <= 1'b1;
      end else if (err_clr) begin
        tmo_flag_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (strobe_d) begin
            addr_q  <= spi_addr;
            if (spi_wr_en) begin
              wdata_q <= spi_wdata;
            end
            we_q    <= spi_wr_en;
            req_q   <= 1'b1;
            timer_q <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // An ack on the final timer cycle still completes the transaction normally.
          if (bus_ack) begin
            req_q <= 1'b0;
            if (!we_q) begin
              rdata_q <= bus_rdata;
            end
            state_q <= IDLE;
          end else if (timer_q == TMO_LAST) begin
            req_q <= 1'b0;
            if (!we_q) begin
              rdata_q <= TMO_DATA;
            end
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign spi_rdata   = rdata_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign bus_we      = we_q;
  assign bus_req     = req_q;
  assign busy        = (state_q == WAIT);
  assign err_timeout = tmo_flag_q;
  assign err_overrun = ovr_flag_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_bus_bridge.sv
// tb_spi_bus_bridge: table-driven scoreboard bench for spi_bus_bridge. Rev 1.0
`default_nettype none

module tb_spi_bus_bridge;

  localparam int          ASZ      = 7;
  localparam int          DSZ      = 32;
  localparam int          TMO      = 16;
  localparam logic [31:0] TMO_DATA = 32'hDEADBEEF;

  logic           clk;
  logic           reset_n;
  logic [ASZ-1:0] spi_addr;
  logic [DSZ-1:0] spi_wdata;
  logic           spi_wr_en;
  logic           spi_rd_en;
  logic [DSZ-1:0] spi_rdata;
  logic [ASZ-1:0] bus_addr;
  logic [DSZ-1:0] bus_wdata;
  logic           bus_we;
  logic           bus_req;
  logic           bus_ack;
  logic [DSZ-1:0] bus_rdata;
  logic           busy;
  logic           err_timeout;
  logic           err_overrun;
  logic           err_clr;

  spi_bus_bridge #(
    .ASZ      (ASZ),
    .DSZ      (DSZ),
    .TMO      (TMO),
    .TMO_DATA (TMO_DATA)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .spi_addr    (spi_addr),
    .spi_wdata   (spi_wdata),
    .spi_wr_en   (spi_wr_en),
    .spi_rd_en   (spi_rd_en),
    .spi_rdata   (spi_rdata),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_we      (bus_we),
    .bus_req     (bus_req),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun),
    .err_clr     (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] brdata;
    int          ack_dly;   // cycles after the strobe edge before ack; -1 = never
    logic [31:0] exp_rdata;
    bit          exp_we;
    int          exp_req;
    bit          exp_tmo;
    bit          exp_ovr;
  } vec_t;

  vec_t vecs [7];
  vec_t sb_q [$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    int   cyc;
    int   req_cnt;
    pulse_clr();
    spi_wr_en = v.wr;
    spi_rd_en = v.rd;
    spi_addr  = v.addr;
    spi_wdata = v.wdata;
    sb_q.push_back(v);
    @(negedge clk);
    spi_wr_en = 1'b0;
    spi_rd_en = 1'b0;
    spi_addr  = 7'($urandom);
    spi_wdata = $urandom;
    check("req_rise",  64'(bus_req),  64'(1));
    check("busy_rise", 64'(busy),     64'(1));
    check("bus_we",    64'(bus_we),   64'(v.exp_we));
    check("bus_addr",  64'(bus_addr), 64'(v.addr));
    if (v.wr) check("bus_wdata", 64'(bus_wdata), 64'(v.wdata));
    cyc     = 0;
    req_cnt = 0;
    while (bus_req === 1'b1 && cyc < TMO + 4) begin
      req_cnt++;
      if (cyc == v.ack_dly) begin
        bus_ack   = 1'b1;
        bus_rdata = v.brdata;
      end else begin
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
      end
      @(negedge clk);
      bus_ack = 1'b0;
      cyc++;
    end
    e = sb_q.pop_front();
    check("req_fall",    64'(bus_req),     64'(0));
    check("req_cycles",  64'(req_cnt),     64'(e.exp_req));
    check("spi_rdata",   64'(spi_rdata),   64'(e.exp_rdata));
    check("busy_done",   64'(busy),        64'(0));
    check("err_timeout", 64'(err_timeout), 64'(e.exp_tmo));
    check("err_overrun", 64'(err_overrun), 64'(e.exp_ovr));
  endtask

  task automatic late_ack_check();
    @(negedge clk);
    bus_ack   = 1'b1;
    bus_rdata = 32'h1234ABCD;
    @(negedge clk);
    bus_ack   = 1'b0;
    check("late_ack_rdata", 64'(spi_rdata),   64'(32'hDEADBEEF));
    check("late_ack_req",   64'(bus_req),     64'(0));
    check("late_ack_busy",  64'(busy),        64'(0));
    check("late_ack_tmo",   64'(err_timeout), 64'(1));
  endtask

  task automatic overrun_seq();
    int extra;
    pulse_clr();
    spi_wr_en = 1'b1; spi_addr = 7'h10; spi_wdata = 32'h0000_0001;
    @(negedge clk);
    spi_wr_en = 1'b0;
    @(negedge clk);
    spi_wr_en = 1'b1; spi_addr = 7'h20; spi_wdata = 32'h0000_0002;
    @(negedge clk);
    spi_wr_en = 1'b0;
    check("ovr_set",       64'(err_overrun), 64'(1));
    check("ovr_keep_addr", 64'(bus_addr),    64'(7'h10));
    check("ovr_keep_data", 64'(bus_wdata),   64'(32'h1));
    check("ovr_req_held",  64'(bus_req),     64'(1));
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus_req === 1'b1) extra++;
      @(negedge clk);
    end
    check("ovr_single_txn", 64'(extra), 64'(0));
    // new read, then err_clr coincident with a dropped strobe
    spi_rd_en = 1'b1; spi_addr = 7'h21;
    @(negedge clk);
    spi_rd_en = 1'b1; err_clr = 1'b1; spi_addr = 7'h22;
    @(negedge clk);
    spi_rd_en = 1'b0; err_clr = 1'b0;
    check("ovr_set_wins", 64'(err_overrun), 64'(1));
    check("ovr2_addr",    64'(bus_addr),    64'(7'h21));
    bus_ack = 1'b1; bus_rdata = 32'h600DD00D;
    @(negedge clk);
    bus_ack = 1'b0;
    check("ovr2_rdata", 64'(spi_rdata), 64'(32'h600DD00D));
    pulse_clr();
    check("clr_ovr", 64'(err_overrun), 64'(0));
    check("clr_tmo", 64'(err_timeout), 64'(0));
  endtask

  task automatic reset_mid_seq();
    vec_t v;
    @(negedge clk);
    spi_rd_en = 1'b1; spi_addr = 7'h05;
    @(negedge clk);
    spi_rd_en = 1'b0;
    @(negedge clk);
    check("rst_mid_busy_before", 64'(busy), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_req",   64'(bus_req),   64'(0));
    check("rst_mid_busy",  64'(busy),      64'(0));
    check("rst_mid_rdata", 64'(spi_rdata), 64'(0));
    check("rst_mid_addr",  64'(bus_addr),  64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    v = '{1'b0, 1'b1, 7'h0A, 32'h0, 32'hFEEDFACE, 2, 32'hFEEDFACE, 1'b0, 3, 1'b0, 1'b0};
    run_vec(v);
  endtask

  initial begin
    reset_n   = 1'b0;
    spi_addr  = '0;
    spi_wdata = '0;
    spi_wr_en = 1'b0;
    spi_rd_en = 1'b0;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    err_clr   = 1'b0;

    //            wr    rd    addr   wdata         brdata        dly rdata         we   req tmo   ovr
    vecs[0] = '{1'b1, 1'b0, 7'h15, 32'h12345678, 32'h99999999,  3, 32'h00000000, 1'b1,  4, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 7'h02, 32'h0,        32'hCAFEF00D,  0, 32'hCAFEF00D, 1'b0,  1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 7'h7F, 32'h0,        32'h11111111, -1, 32'hDEADBEEF, 1'b0, 16, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 7'h40, 32'hA5A5A5A5, 32'h77777777,  1, 32'hDEADBEEF, 1'b1,  2, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 7'h33, 32'h0,        32'h0BADF00D,  5, 32'h0BADF00D, 1'b0,  6, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 7'h00, 32'hFFFFFFFF, 32'h12121212, 15, 32'h0BADF00D, 1'b1, 16, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 7'h01, 32'h0,        32'h5555AAAA, 14, 32'h5555AAAA, 1'b0, 15, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_rdata", 64'(spi_rdata),   64'(0));
    check("rst_addr",  64'(bus_addr),    64'(0));
    check("rst_wdata", 64'(bus_wdata),   64'(0));
    check("rst_we",    64'(bus_we),      64'(0));
    check("rst_req",   64'(bus_req),     64'(0));
    check("rst_busy",  64'(busy),        64'(0));
    check("rst_tmo",   64'(err_timeout), 64'(0));
    check("rst_ovr",   64'(err_overrun), 64'(0));
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
      if (i == 2) late_ack_check();
    end

    overrun_seq();
    reset_mid_seq();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
